// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, stall encoding and bus layouts for the IF stage.
package if_fetch_stage_pkg;

  localparam int STALL_BUS = 6;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD = 33;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

endpackage

// File: rtl/if_inst_hold_buf.sv
// Captures the fetched instruction on the first IF/ID stall cycle and replays it
// to ID until the stall lifts, so a changing SRAM read port cannot corrupt ID.
module if_inst_hold_buf
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] id_inst
);

  logic        hold_vld_d, hold_vld_q;
  logic [31:0] hold_data_d, hold_data_q;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (hold == NO_STOP) begin
      hold_vld_d = 1'b0;
    end else if (!hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_data_d = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= 32'h0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign id_inst = hold_vld_q ? hold_data_q : inst_sram_rdata;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC register, branch redirect (with stall-safe pending redirect),
// instruction SRAM request. Optional macro FETCH_ADDR_CHECK_EN adds misaligned-fetch detection.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          STALL_W  = STALL_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            id_inst,
  output logic                   if_excp_adel
);

  br_bus_t     br;
  if_to_id_t   out_bus;
  logic [31:0] pc_d, pc_q;
  logic        ce_d, ce_q;
  logic        br_pend_d, br_pend_q;
  logic [31:0] br_tgt_d, br_tgt_q;
  logic [31:0] buf_inst;
  logic        unused_stall;

  assign br           = br_bus;
  assign unused_stall = ^stall[STALL_W-1:2];

  always_comb begin
    pc_d      = pc_q;
    ce_d      = 1'b1;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    if (!ce_q) begin
      pc_d      = RESET_PC;
      br_pend_d = 1'b0;
    end else if (stall[0] == STOP) begin
      // Remember the redirect; the latest one seen during the stall wins.
      if (br.br_e) begin
        br_pend_d = 1'b1;
        br_tgt_d  = br.br_addr;
      end
    end else if (br.br_e) begin
      pc_d      = br.br_addr;
      br_pend_d = 1'b0;
    end else if (br_pend_q) begin
      pc_d      = br_tgt_q;
      br_pend_d = 1'b0;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC - 32'd4;
      ce_q      <= 1'b0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
    end
  end

  assign out_bus.ce      = ce_q;
  assign out_bus.pc      = pc_q;
  assign if_to_id_bus    = out_bus;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  if_inst_hold_buf u_hold_buf (
    .clk             (clk),
    .rst             (rst),
    .hold            (stall[1]),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (buf_inst)
  );

`ifdef FETCH_ADDR_CHECK_EN
  logic adel_d, adel_q;

  assign if_excp_adel = ce_q & (pc_q[1:0] != 2'b00);
  assign inst_sram_en = ce_q & ~if_excp_adel;

  always_comb begin
    adel_d = if_excp_adel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) adel_q <= 1'b0;
    else     adel_q <= adel_d;
  end

  // A misaligned fetch never reached the SRAM; hand ID a nop instead.
  assign id_inst = adel_q ? 32'h0 : buf_inst;
`else
  assign if_excp_adel = 1'b0;
  assign inst_sram_en = ce_q;
  assign id_inst      = buf_inst;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage plus hand sequences for
// reset-during-stall and the optional misaligned-fetch check.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_inst;
  logic        if_excp_adel;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst),
    .if_excp_adel    (if_excp_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic [31:0] exp_id;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stall, br_e, br_addr, rdata, expected pc after the edge, expected id_inst
    vecs[0]  = '{6'd0, 1'b0, 32'h0,         32'hA000_0000, 32'hBFC0_0000, 32'hA000_0000};
    vecs[1]  = '{6'd0, 1'b0, 32'h0,         32'hA000_0001, 32'hBFC0_0004, 32'hA000_0001};
    vecs[2]  = '{6'd0, 1'b0, 32'h0,         32'hA000_0002, 32'hBFC0_0008, 32'hA000_0002};
    vecs[3]  = '{6'd0, 1'b1, 32'hBFC0_0100, 32'hA000_0003, 32'hBFC0_0100, 32'hA000_0003};
    vecs[4]  = '{6'd0, 1'b0, 32'h0,         32'hA000_0004, 32'hBFC0_0104, 32'hA000_0004};
    vecs[5]  = '{6'd1, 1'b1, 32'hBFC0_0200, 32'hA000_0005, 32'hBFC0_0104, 32'hA000_0005};
    vecs[6]  = '{6'd1, 1'b0, 32'h0,         32'hA000_0006, 32'hBFC0_0104, 32'hA000_0006};
    vecs[7]  = '{6'd1, 1'b0, 32'h0,         32'hA000_0007, 32'hBFC0_0104, 32'hA000_0007};
    vecs[8]  = '{6'd0, 1'b0, 32'h0,         32'hA000_0008, 32'hBFC0_0200, 32'hA000_0008};
    vecs[9]  = '{6'd0, 1'b0, 32'h0,         32'hA000_0009, 32'hBFC0_0204, 32'hA000_0009};
    vecs[10] = '{6'd3, 1'b0, 32'h0,         32'h1111_1111, 32'hBFC0_0204, 32'h1111_1111};
    vecs[11] = '{6'd3, 1'b0, 32'h0,         32'h2222_2222, 32'hBFC0_0204, 32'h1111_1111};
    vecs[12] = '{6'd3, 1'b0, 32'h0,         32'h3333_3333, 32'hBFC0_0204, 32'h1111_1111};
    vecs[13] = '{6'd3, 1'b0, 32'h0,         32'h4444_4444, 32'hBFC0_0204, 32'h1111_1111};
    vecs[14] = '{6'd0, 1'b0, 32'h0,         32'h5555_5555, 32'hBFC0_0208, 32'h5555_5555};
    vecs[15] = '{6'd0, 1'b0, 32'h0,         32'h6666_6666, 32'hBFC0_020C, 32'h6666_6666};
    vecs[16] = '{6'd1, 1'b1, 32'hBFC0_0300, 32'hA000_0010, 32'hBFC0_020C, 32'hA000_0010};
    vecs[17] = '{6'd1, 1'b1, 32'hBFC0_0400, 32'hA000_0011, 32'hBFC0_020C, 32'hA000_0011};
    vecs[18] = '{6'd0, 1'b1, 32'hBFC0_0500, 32'hA000_0012, 32'hBFC0_0500, 32'hA000_0012};
    vecs[19] = '{6'd0, 1'b0, 32'h0,         32'hA000_0013, 32'hBFC0_0504, 32'hA000_0013};
    vecs[20] = '{6'd0, 1'b1, 32'hFFFF_FFFC, 32'hA000_0014, 32'hFFFF_FFFC, 32'hA000_0014};
    vecs[21] = '{6'd0, 1'b0, 32'h0,         32'hA000_0015, 32'h0000_0000, 32'hA000_0015};
    vecs[22] = '{6'd0, 1'b0, 32'h0,         32'hA000_0016, 32'h0000_0004, 32'hA000_0016};

    rst = 1'b1;
    stall = 6'd0;
    br_bus = 33'h0;
    inst_sram_rdata = 32'hDEAD_BEEF;
    step();
    step();
    chk("reset_bus", if_to_id_bus, 33'h0_BFBF_FFFC);
    chk("reset_en", {32'h0, inst_sram_en}, 33'h0);
    chk("reset_id_inst", {1'b0, id_inst}, {1'b0, 32'hDEAD_BEEF});
    chk("reset_adel", {32'h0, if_excp_adel}, 33'h0);
    chk("reset_wen_wdata", {inst_sram_wen, inst_sram_wdata[28:0]}, 33'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall           = vecs[i].stall;
      br_bus          = {vecs[i].br_e, vecs[i].br_addr};
      inst_sram_rdata = vecs[i].rdata;
      step();
      chk($sformatf("row%0d_bus", i), if_to_id_bus, {1'b1, vecs[i].exp_pc});
      chk($sformatf("row%0d_addr", i), {1'b0, inst_sram_addr}, {1'b0, vecs[i].exp_pc});
      chk($sformatf("row%0d_en", i), {32'h0, inst_sram_en}, 33'h1);
      chk($sformatf("row%0d_id_inst", i), {1'b0, id_inst}, {1'b0, vecs[i].exp_id});
    end

    // Reset in the middle of a PC stall with a redirect pending.
    stall  = 6'd1;
    br_bus = {1'b1, 32'hBFC0_0700};
    step();
    chk("pend_pc_held", if_to_id_bus, {1'b1, 32'h0000_0004});
    br_bus = 33'h0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_bus", if_to_id_bus, 33'h0_BFBF_FFFC);
    chk("midrst_en", {32'h0, inst_sram_en}, 33'h0);
    step();
    rst   = 1'b0;
    stall = 6'd0;
    step();
    chk("post_rst_pc0", if_to_id_bus, {1'b1, 32'hBFC0_0000});
    step();
    chk("post_rst_pc1", if_to_id_bus, {1'b1, 32'hBFC0_0004});

    // Redirect to a misaligned address.
    br_bus          = {1'b1, 32'hBFC0_0102};
    inst_sram_rdata = 32'h7777_7777;
    step();
    br_bus = 33'h0;
    chk("mis_pc", if_to_id_bus, {1'b1, 32'hBFC0_0102});
`ifdef FETCH_ADDR_CHECK_EN
    chk("mis_adel", {32'h0, if_excp_adel}, 33'h1);
    chk("mis_en", {32'h0, inst_sram_en}, 33'h0);
    step();
    chk("mis_id_nop", {1'b0, id_inst}, 33'h0);
`else
    chk("mis_adel", {32'h0, if_excp_adel}, 33'h0);
    chk("mis_en", {32'h0, inst_sram_en}, 33'h1);
    step();
    chk("mis_id_inst", {1'b0, id_inst}, {1'b0, 32'h7777_7777});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
